// File: rtl/adc_sample_packer_if.sv
// Sample-in / packed-word-out bundle between the ADC capture stage and the packer.
// The master side drives samples and controls; the slave side returns packed words.
interface adc_sample_packer_if #(
  parameter int WORD_COUNT_WIDTH = 16
);
  logic [9:0]                  inData;
  logic                        inValid;
  logic                        flush;
  logic                        restart;
  logic [15:0]                 outData;
  logic                        outValid;
  logic                        outSync;
  logic                        outPartial;
  logic [WORD_COUNT_WIDTH-1:0] wordCount;

  modport master (
    output inData, inValid, flush, restart,
    input  outData, outValid, outSync, outPartial, wordCount
  );

  modport slave (
    input  inData, inValid, flush, restart,
    output outData, outValid, outSync, outPartial, wordCount
  );
endinterface

// File: rtl/adc_sample_packer.sv
// Packs a continuous LSB-first stream of 10-bit ADC samples into dense 16-bit words
// (8 samples -> 5 words), with flush of residual bits, restart and group-sync marking.
module adc_sample_packer #(
  parameter int WORD_COUNT_WIDTH = 16
) (
  input  logic                clock,
  input  logic                nReset,
  adc_sample_packer_if.slave  bus
);

  logic [25:0]                 acc_q, acc_d;
  logic [3:0]                  bit_cnt_q, bit_cnt_d;
  logic [2:0]                  word_idx_q, word_idx_d;
  logic                        flush_pend_q, flush_pend_d;
  logic [15:0]                 out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_sync_q, out_sync_d;
  logic                        out_partial_q, out_partial_d;
  logic [WORD_COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  logic [25:0] acc_ins;
  logic        full_word;
  logic        flush_now;

  // With at most 15 residual bits, the new sample lands in bits [24:0].
  assign acc_ins   = acc_q | ({16'd0, bus.inData} << bit_cnt_q);
  assign full_word = (bit_cnt_q >= 4'd6);
  assign flush_now = bus.flush | flush_pend_q;

  always_comb begin
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    flush_pend_d  = flush_pend_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    out_sync_d    = 1'b0;
    out_partial_d = 1'b0;
    word_cnt_d    = word_cnt_q;

    if (bus.restart) begin
      acc_d        = '0;
      bit_cnt_d    = '0;
      word_idx_d   = '0;
      flush_pend_d = 1'b0;
      word_cnt_d   = '0;
    end else if (bus.inValid) begin
      // A flush arriving with a sample is deferred to the next idle cycle.
      if (bus.flush) begin
        flush_pend_d = 1'b1;
      end
      if (full_word) begin
        out_data_d  = acc_ins[15:0];
        out_valid_d = 1'b1;
        out_sync_d  = (word_idx_q == 3'd0);
        word_idx_d  = (word_idx_q == 3'd4) ? 3'd0 : word_idx_q + 3'd1;
        acc_d       = {16'd0, acc_ins[25:16]};
        bit_cnt_d   = bit_cnt_q - 4'd6;
        word_cnt_d  = word_cnt_q + WORD_COUNT_WIDTH'(1);
      end else begin
        acc_d     = acc_ins;
        bit_cnt_d = bit_cnt_q + 4'd10;
      end
    end else if (flush_now) begin
      flush_pend_d = 1'b0;
      word_idx_d   = '0;
      if (bit_cnt_q != 4'd0) begin
        out_data_d    = acc_q[15:0];
        out_valid_d   = 1'b1;
        out_partial_d = 1'b1;
        out_sync_d    = (word_idx_q == 3'd0);
        acc_d         = '0;
        bit_cnt_d     = '0;
        word_cnt_d    = word_cnt_q + WORD_COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      acc_q         <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      flush_pend_q  <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sync_q    <= 1'b0;
      out_partial_q <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      flush_pend_q  <= flush_pend_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sync_q    <= out_sync_d;
      out_partial_q <= out_partial_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

  assign bus.outData    = out_data_q;
  assign bus.outValid   = out_valid_q;
  assign bus.outSync    = out_sync_q;
  assign bus.outPartial = out_partial_q;
  assign bus.wordCount  = word_cnt_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: bit-queue reference model, per-cycle compare, directed
// scenarios with literal expectations, then a randomized phase.
module tb_adc_sample_packer;
  localparam int WCW = 16;

  logic clock = 1'b0;
  logic nReset;
  always #5 clock = ~clock;

  adc_sample_packer_if #(.WORD_COUNT_WIDTH(WCW)) bus ();
  adc_sample_packer #(.WORD_COUNT_WIDTH(WCW)) dut (
    .clock (clock),
    .nReset(nReset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: the stream is a plain queue of bits, words are popped 16 at a time.
  typedef struct {
    logic [15:0] d;
    logic        s;
    logic        p;
  } wrec_t;

  bit          mq[$];
  int          m_grp;
  bit          m_fp;
  logic [15:0] mw;
  logic [15:0] e_data;
  logic        e_valid, e_sync, e_part;
  logic [WCW-1:0] e_wc;
  wrec_t       m_log[$];

  task automatic rec(input logic [15:0] w, input logic s, input logic p);
    wrec_t r;
    e_data  = w;
    e_valid = 1'b1;
    e_sync  = s;
    e_part  = p;
    e_wc    = e_wc + 1'b1;
    r.d = w; r.s = s; r.p = p;
    m_log.push_back(r);
  endtask

  always @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      mq.delete();
      m_grp = 0; m_fp = 0;
      e_data = '0; e_valid = 0; e_sync = 0; e_part = 0; e_wc = '0;
    end else begin
      e_valid = 0; e_sync = 0; e_part = 0;
      if (bus.restart) begin
        mq.delete();
        m_grp = 0; m_fp = 0; e_wc = '0;
      end else if (bus.inValid) begin
        if (bus.flush) m_fp = 1;
        for (int i = 0; i < 10; i++) mq.push_back(bus.inData[i]);
        if (mq.size() >= 16) begin
          for (int i = 0; i < 16; i++) mw[i] = mq.pop_front();
          rec(mw, m_grp == 0, 1'b0);
          m_grp = (m_grp + 1) % 5;
        end
      end else if (bus.flush || m_fp) begin
        m_fp = 0;
        if (mq.size() > 0) begin
          mw = '0;
          for (int i = 0; mq.size() > 0; i++) mw[i] = mq.pop_front();
          rec(mw, m_grp == 0, 1'b1);
        end
        m_grp = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      checks++;
      if ({bus.outData, bus.outValid, bus.outSync, bus.outPartial, bus.wordCount} !==
          {e_data, e_valid, e_sync, e_part, e_wc}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got data=%h v=%b s=%b p=%b wc=%0d want data=%h v=%b s=%b p=%b wc=%0d",
                 $time, bus.outData, bus.outValid, bus.outSync, bus.outPartial, bus.wordCount,
                 e_data, e_valid, e_sync, e_part, e_wc);
      end
    end
  end

  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic chk_log(input string n, input int idx, input logic [15:0] d,
                         input logic s, input logic p);
    if (idx < m_log.size())
      lit(n, {14'd0, m_log[idx].p, m_log[idx].s, m_log[idx].d}, {14'd0, p, s, d});
  endtask

  task automatic cyc(input logic v, input logic [9:0] d, input logic f, input logic r);
    @(posedge clock);
    #1;
    bus.inValid = v; bus.inData = d; bus.flush = f; bus.restart = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  logic [15:0] s1w[5];

  task automatic scen1(input string tag);
    m_log.delete();
    for (int k = 1; k <= 8; k++) cyc(1'b1, 10'(k), 1'b0, 1'b0);
    idle(3);
    lit({tag, "_count"}, m_log.size(), 5);
    for (int i = 0; i < 5; i++) chk_log({tag, "_word"}, i, s1w[i], i == 0, 1'b0);
    lit({tag, "_wordCount"}, {16'd0, bus.wordCount}, 32'd5);
  endtask

  initial begin
    s1w[0] = 16'h0801; s1w[1] = 16'h0030; s1w[2] = 16'h0501;
    s1w[3] = 16'h7018; s1w[4] = 16'h0200;
    bus.inValid = 0; bus.inData = '0; bus.flush = 0; bus.restart = 0;
    nReset = 1'b1;
    #2 nReset = 1'b0;
    #1 cmp_en = 1'b1;
    lit("reset_outputs", {bus.outData, 3'b0, bus.outValid, bus.outSync, bus.outPartial},
        32'h0);
    lit("reset_wordCount", {16'd0, bus.wordCount}, 32'd0);
    idle(2);
    nReset = 1'b1;

    // Scenario 1: samples 1..8 -> five words
    scen1("s1");

    // Scenario 2: sixteen full-scale samples
    m_log.delete();
    for (int k = 0; k < 16; k++) cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
    idle(2);
    lit("s2_count", m_log.size(), 10);
    for (int i = 0; i < 10; i++) chk_log("s2_word", i, 16'hFFFF, (i == 0) || (i == 5), 1'b0);

    // Scenario 3: flush of a lone sample, then realigned pair
    m_log.delete();
    cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    cyc(1'b1, 10'h155, 1'b0, 1'b0);
    cyc(1'b1, 10'h2AA, 1'b0, 1'b0);
    idle(2);
    lit("s3_count", m_log.size(), 2);
    chk_log("s3_partial", 0, 16'h03FF, 1'b1, 1'b1);
    chk_log("s3_realign", 1, 16'hA955, 1'b1, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    idle(2);

    // Scenario 4: flush concurrent with a word-completing sample
    m_log.delete();
    for (int k = 0; k < 6; k++) cyc(1'b1, 10'h3FF, 1'b0, 1'b0);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    idle(3);
    lit("s4_count", m_log.size(), 5);
    chk_log("s4_full", 3, 16'hFFFF, 1'b0, 1'b0);
    chk_log("s4_residue", 4, 16'h003F, 1'b0, 1'b1);

    // Scenario 5: restart drops concurrent sample and all state
    for (int k = 0; k < 3; k++) cyc(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
    cyc(1'b1, 10'h2A5, 1'b1, 1'b1);
    scen1("s5");

    // Scenario 6: asynchronous reset mid-group
    for (int k = 0; k < 3; k++) cyc(1'b1, 10'($urandom_range(0, 1023)), 1'b0, 1'b0);
    @(posedge clock);
    #1;
    bus.inValid = 0;
    #2 nReset = 1'b0;
    #1;
    lit("s6_async_outputs", {bus.outData, 3'b0, bus.outValid, bus.outSync, bus.outPartial},
        32'h0);
    lit("s6_async_wordCount", {16'd0, bus.wordCount}, 32'd0);
    idle(2);
    nReset = 1'b1;
    scen1("s6");

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 9) < 7), 10'($urandom_range(0, 1023)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 2));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
